// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-2 Booth multiplier for the MUL instruction.
// Latches two signed WIDTH-bit operands on start, performs one Booth step per
// clock, pulses done for one cycle and holds the 2*WIDTH-bit product on hi/lo.
//
// Optional feature macro: BOOTH_EARLY_EXIT_EN
//   When defined, an ITER step whose remaining multiplier bits all equal q0
//   (so every remaining step would be a pure shift) collapses all remaining
//   shifts into a single cycle and finishes immediately.
//
// Handshake: start is a request sampled only in IDLE or DONE; the owner waits
// for the one-cycle done pulse, at which point hi/lo already hold the product.
// busy is high whenever the FSM is not in IDLE. All outputs are registered.
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH:0]   a_q;      // accumulator with sign guard bit
  logic [WIDTH:0]   m_q;      // sign-extended multiplicand
  logic [WIDTH-1:0] q_q;      // multiplier, shifted right each step
  logic             q0_q;     // bit shifted out of Q on the previous step
  logic [CW-1:0]    cnt_q;    // steps already performed
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH:0]   s_d;
  logic [WIDTH:0]   a_d;
  logic [WIDTH-1:0] q_d;

  // One Booth step: add/subtract/keep M based on {Q[0],q0}, then shift right.
  always_comb begin
    s_d = a_q;
    case ({q_q[0], q0_q})
      2'b10:   s_d = a_q - m_q;
      2'b01:   s_d = a_q + m_q;
      default: s_d = a_q;
    endcase
    a_d = {s_d[WIDTH], s_d[WIDTH:1]};
    q_d = {s_d[0], q_q[WIDTH-1:1]};
  end

`ifdef BOOTH_EARLY_EXIT_EN
  logic [WIDTH-1:0]        ee_mask;
  logic                    ee_hit;
  logic [CW-1:0]           ee_sh;
  logic signed [2*WIDTH:0] ee_aq;

  // Detect that every unexamined multiplier bit equals q0; the remaining
  // steps are then pure arithmetic shifts, done here all at once.
  always_comb begin
    ee_mask = {WIDTH{1'b1}} >> cnt_q;
    ee_hit  = ((q_q ^ {WIDTH{q0_q}}) & ee_mask) == '0;
    ee_sh   = CW'(WIDTH) - cnt_q;
    ee_aq   = $signed({a_q, q_q}) >>> ee_sh;
  end
`endif

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q0_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_q     <= '0;
            m_q     <= {op_a[WIDTH-1], op_a};
            q_q     <= op_b;
            q0_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ITER;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_ITER: begin
`ifdef BOOTH_EARLY_EXIT_EN
          if (ee_hit) begin
            a_q     <= ee_aq[2*WIDTH:WIDTH];
            q_q     <= ee_aq[WIDTH-1:0];
            hi_q    <= ee_aq[2*WIDTH-1:WIDTH];
            lo_q    <= ee_aq[WIDTH-1:0];
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else
`endif
          begin
            a_q   <= a_d;
            q_q   <= q_d;
            q0_q  <= q_q[0];
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              hi_q    <= a_d[WIDTH-1:0];
              lo_q    <= q_d;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed testbench for booth_mul_seq (WIDTH=32), latency expectations
// follow BOOTH_EARLY_EXIT_EN when it is defined for the build.
module tb_booth_mul_seq;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  int lat;
  int ndone;

  // Clock generation.
  always #5 clock = ~clock;

  booth_mul_seq #(.WIDTH(W)) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input int early);
`ifdef BOOTH_EARLY_EXIT_EN
    return early;
`else
    return 33;
`endif
  endfunction

  // Called at a sample point; returns just after edge 0 with start dropped
  // and the operand inputs scrambled.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  // Counts edges (edge 0 counted as 1) until done is seen; 0 on timeout.
  task automatic wait_done(input int lat_in, output int lat_out);
    bit found;
    int n;
    found = 1'b0;
    n = 0;
    lat_out = lat_in;
    while (!found && n < 100) begin
      @(posedge clock); #1;
      lat_out++;
      n++;
      if (done === 1'b1) found = 1'b1;
    end
    if (!found) lat_out = 0;
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
      if (done !== 1'b0) cnt++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [63:0] exp_prod, input int early_lat);
    int l;
    launch(a, b);
    check({tag, " busy_after_start"}, {63'd0, busy}, 64'd1);
    wait_done(1, l);
    check({tag, " latency"}, 64'(l), 64'(exp_lat(early_lat)));
    check({tag, " product"}, {hi, lo}, exp_prod);
    @(posedge clock); #1;
    check({tag, " done_pulse_end"}, {63'd0, done}, 64'd0);
    check({tag, " held_product"}, {hi, lo}, exp_prod);
  endtask

  initial begin
    // Reset: two cycles of clear.
    clear = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b0;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset product", {hi, lo}, 64'd0);
    check("reset state", {62'd0, dbg_state}, 64'd0);
    @(posedge clock); #1;

    // Basic and boundary signed products.
    run_op("7x-3", 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 5);
    run_op("min_x_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33);
    run_op("min_x_1", 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, 4);

    // start held high during ITER gives a single done.
    op_a  = 32'd7;
    op_b  = 32'hFFFF_FFFD;
    start = 1'b1;
    @(posedge clock); #1;
    op_a = $urandom;
    op_b = $urandom;
    @(posedge clock); #1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(3, lat);
    check("held_start latency", 64'(lat), 64'(exp_lat(5)));
    check("held_start product", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    count_dones(40, ndone);
    check("held_start extra_dones", 64'(ndone), 64'd0);

    // Back-to-back: start accepted during DONE.
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, lat);
    check("m1xm1 latency", 64'(lat), 64'(exp_lat(3)));
    check("m1xm1 product", {hi, lo}, 64'd1);
    launch(32'd5, 32'd6);
    check("b2b busy", {63'd0, busy}, 64'd1);
    check("b2b done_low", {63'd0, done}, 64'd0);
    check("b2b hold_prev", {hi, lo}, 64'd1);
    wait_done(1, lat);
    check("b2b latency", 64'(lat), 64'(exp_lat(6)));
    check("b2b product", {hi, lo}, 64'd30);
    @(posedge clock); #1;
    check("b2b idle", {63'd0, busy}, 64'd0);

    // clear in the middle of an operation.
    launch(32'h8000_0000, 32'h8000_0000);
    repeat (9) begin
      @(posedge clock); #1;
    end
    clear = 1'b1;
    #1;
    check("clear busy", {63'd0, busy}, 64'd0);
    check("clear done", {63'd0, done}, 64'd0);
    check("clear product", {hi, lo}, 64'd0);
    check("clear state", {62'd0, dbg_state}, 64'd0);
    @(posedge clock); #1;
    clear = 1'b0;
    count_dones(40, ndone);
    check("clear no_done", 64'(ndone), 64'd0);
    run_op("after_clear 5x6", 32'd5, 32'd6, 64'd30, 6);

    // Early-exit shaped operands (full latency when the feature is off).
    run_op("b_zero", 32'd123, 32'd0, 64'd0, 2);
    run_op("9xm1", 32'd9, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF7, 3);
    run_op("ax1", 32'h1234_5678, 32'd1, 64'h0000_0000_1234_5678, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mul_seq.md
# booth_mul_seq

Sequential radix-2 Booth multiplier controller for the CPU's MUL instruction. Latches two signed WIDTH-bit operands on a start pulse and runs one Booth step per clock. Reports completion with a one-cycle done pulse and holds the 2·WIDTH-bit product for the HI/LO registers. The datapath control unit owns this block: it issues start and waits for done before writing HI/LO.

## Interface
- WIDTH, 32, operand width in bits; the product is 2·WIDTH bits.

- clock  input  1  system clock; rising edge active.
- clear  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- op_a  input  WIDTH  multiplicand M, signed two's complement.
- op_b  input  WIDTH  multiplier Q, signed two's complement.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse; the result is valid in the same cycle.
- hi  output  WIDTH  product[2·WIDTH-1:WIDTH].
- lo  output  WIDTH  product[WIDTH-1:0].

## Operation
- **States:** IDLE, ITER, DONE.
- **Reset state:** IDLE. busy=0, done=0, hi=lo=0.
- **Internal registers:**
  - A: WIDTH+1 bits, sign guard bit included.
  - M: WIDTH+1 bits, sign-extended op_a.
  - Q: WIDTH bits.
  - q0: 1 bit.
  - count: ceil(log2(WIDTH+1)) bits.
- **IDLE or DONE with start=1:**
  - Load A=0, M=sext(op_a), Q=op_b, q0=0, count=0.
  - Go to ITER.
- **IDLE with start=0:** stay in IDLE.
- **DONE with start=0:** go to IDLE.
- **ITER, one Booth step per cycle:**
  - Compute S from pair {Q[0],q0}:
    - 10: S=A−M.
    - 01: S=A+M.
    - 00 or 11: S=A.
  - Shift the concatenation {S,Q,q0} right arithmetically by one:
    - q0←Q[0].
    - Q←{S[0],Q[WIDTH-1:1]}.
    - A←{S[WIDTH],S[WIDTH:1]}.
  - count←count+1.
  - When count reaches WIDTH−1 (i.e. this is the final step), go to DONE.
- **Product:**
  - Defined as {A[WIDTH-1:0],Q}.
  - The guard bit guarantees correctness for M = −2^(WIDTH−1).
- **Result registers:**
  - hi/lo load on the same edge that enters DONE.
  - They hold until the next completion or clear.
  - They are not modified when start is accepted.
- **start while in ITER:** ignored; no queuing.
- **clear mid-operation:**
  - Immediate return to IDLE.
  - busy=0, done=0, hi=lo=0.
  - No done pulse is produced for the aborted operation.

## Timing
- **Edge numbering:** edge 0 is the rising edge at which start=1 is sampled.
- **Steps:** Booth steps occur on edges 1…WIDTH.
- **done:** high during the cycle after edge WIDTH, for exactly one cycle.
- **Latency:** WIDTH+1 cycles from the start edge to done (33 for WIDTH=32).
- **busy:** high from after edge 0 through the DONE cycle.
- **Back-to-back operation:**
  - start=1 during the DONE cycle is accepted.
  - busy stays high.
  - The next done follows WIDTH+1 cycles after that edge.
- **Operand sampling:** operands are sampled only at the start edge; later changes have no effect.
- **Output timing:** all outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **Macro:** BOOTH_EARLY_EXIT_EN.
- **Defined:**
  - Before each ITER step, the block checks two conditions:
    - every bit of Q[WIDTH-1-count:0] equals q0;
    - that check includes the not-yet-examined multiplier bits.
  - If both hold, all remaining steps are pure arithmetic shifts.
  - The block then performs all remaining shifts in one cycle: {A,Q} shifted arithmetically right by WIDTH−count.
  - It then goes to DONE.
  - Latency varies from 2 to WIDTH+1 cycles. The product is identical to the full-latency result.
- **Undefined:** fixed WIDTH+1 cycle latency; no early-exit logic is synthesized.

## Test plan
- **Reset:** assert clear for 2 cycles, then release → busy=0, done=0, hi=lo=0.
- **Basic signed product:** op_a=7, op_b=−3, start pulse → done exactly 33 cycles later; {hi,lo}=64'hFFFF_FFFF_FFFF_FFEB. With the macro: same value, done no earlier than 2 cycles.
- **Most-negative operands:** op_a=op_b=32'h8000_0000 → {hi,lo}=64'h4000_0000_0000_0000. Also op_a=32'h8000_0000, op_b=1 → 64'hFFFF_FFFF_8000_0000.
- **Back-to-back and ignored start:**
  - 32'hFFFF_FFFF × 32'hFFFF_FFFF → 1.
  - start held high during ITER → still a single done.
  - start during DONE with 5×6 → second done 33 cycles later, {hi,lo}=30.
- **clear mid-operation:**
  - Assert clear at cycle 10 of an operation → immediate busy=0, hi=lo=0, no done.
  - A new start then completes normally.
- **BOOTH_EARLY_EXIT_EN:**
  - op_b=0 → done 2 cycles after start, product 0.
  - op_b=−1, op_a=9 → early exit, {hi,lo}=−9.
  - op_b=32'h0000_0001 → product op_a, latency under 33.
  - With the macro undefined, all three take 33 cycles.
